// File: rtl/mm_pkg.sv
// Shared types and default sizes for the memory-mapped line reader.
package mm_pkg;

  localparam int MM_ADDR_W = 42;
  localparam int MM_LINE_W = 512;
  localparam int MM_DEPTH  = 16;

  typedef logic [MM_ADDR_W-1:0] t_line_addr;
  typedef logic [MM_LINE_W-1:0] t_line;
  typedef logic [15:0]          t_mdata;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } t_state;

endpackage

// File: rtl/mm_rd_fifo.sv
// Response line buffer: DEPTH entries of LINE_W bits with a registered head,
// so the consumer sees the oldest line straight from a flop.
module mm_rd_fifo
  import mm_pkg::*;
#(
  parameter int LINE_W = MM_LINE_W,
  parameter int DEPTH  = MM_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [LINE_W-1:0]        wdata,
  input  logic                     pop,
  output logic [LINE_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic [CW-1:0]     cnt;
  logic              do_pop;

  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr + AW'(1);
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rdata  = head;

  // Pointer and occupancy bookkeeping; push and pop together hold the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_nxt;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Line storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Head register: refill from the next slot, or bypass the incoming line
  // when it becomes the oldest entry.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      if (cnt > CW'(1)) head <= mem[rd_nxt];
      else if (push)    head <= wdata;
    end else if (push && empty) begin
      head <= wdata;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !do_pop));

endmodule

// File: rtl/mm_line_reader.sv
// Streams a contiguous run of cache lines from memory to a compute core:
// issues ordered c0 reads under a credit limit and buffers the responses.
module mm_line_reader
  import mm_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int LINE_W = MM_LINE_W,
  parameter int DEPTH  = MM_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_lines,
  output logic              busy,
  output logic              done,
  output logic              c0_req_valid,
  output logic [ADDR_W-1:0] c0_req_addr,
  output logic [15:0]       c0_req_mdata,
  input  logic              c0_tx_almfull,
  input  logic              c0_rsp_valid,
  input  logic [LINE_W-1:0] c0_rsp_data,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  t_state            state;
  t_state            state_nxt;
  logic [15:0]       num_q;
  logic [15:0]       remaining;
  logic [15:0]       pop_cnt;
  logic [CW-1:0]     credits;
  logic [ADDR_W-1:0] addr_q;
  t_mdata            mdata_q;
  logic              almfull_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign issue     = (state == ST_ISSUE) && (remaining != 16'd0) && !almfull_q &&
                     (credits < CW'(DEPTH));
  assign push      = c0_rsp_valid && (state != ST_IDLE);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && busy && ((pop_cnt + 16'd1) == num_q);

  mm_rd_fifo #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (c0_rsp_data),
    .pop     (pop),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an empty job goes straight to DONE without requests.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (num_lines == 16'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue && (remaining == 16'd1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Job control: length, remaining requests, pop count, credits, pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q        <= '0;
      remaining    <= '0;
      pop_cnt      <= '0;
      credits      <= '0;
      almfull_q    <= 1'b0;
      c0_req_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      almfull_q    <= c0_tx_almfull;
      c0_req_valid <= issue;
      done         <= (state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        num_q     <= num_lines;
        remaining <= num_lines;
        pop_cnt   <= '0;
      end else begin
        if (issue) remaining <= remaining - 16'd1;
        if (pop)   pop_cnt   <= pop_cnt + 16'd1;
      end
      case ({issue, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Request address and sequence index; the address wraps naturally.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start) begin
      addr_q  <= base_addr;
      mdata_q <= '0;
    end else if (issue) begin
      c0_req_addr  <= addr_q;
      c0_req_mdata <= mdata_q;
      addr_q       <= addr_q + ADDR_W'(1);
      mdata_q      <= mdata_q + 16'd1;
    end
  end

  credit_cover_a: assert property (@(posedge clk) disable iff (!reset_n)
    credits >= fifo_count);
  full_credit_a: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_full |-> (credits == CW'(DEPTH)));

endmodule

// File: tb/tb_mm_line_reader.sv
// Scoreboard bench for mm_line_reader with a fixed-latency in-order memory model.
module tb_mm_line_reader;

  localparam int AW  = 42;
  localparam int LW  = 512;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_lines = '0;
  logic          busy, done, c0_req_valid, out_valid, out_last;
  logic [AW-1:0] c0_req_addr;
  logic [15:0]   c0_req_mdata;
  logic          c0_tx_almfull = 1'b0;
  logic          c0_rsp_valid = 1'b0;
  logic [LW-1:0] c0_rsp_data = '0;
  logic [LW-1:0] out_data;
  logic          out_ready = 1'b0;

  mm_line_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .busy(busy), .done(done),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_mdata(c0_req_mdata), .c0_tx_almfull(c0_tx_almfull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [15:0] mdata; } req_t;
  typedef struct packed { logic [LW-1:0] data; logic last; } out_t;
  typedef struct packed { logic [31:0] due; logic [AW-1:0] addr; } pend_t;

  req_t  exp_req[$];
  out_t  exp_out[$];
  pend_t pend[$];
  bit    req_at[int];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int req_seen = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  bit busy_seen = 0;
  logic prev_done = 1'b0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{{22'h15A5A5, a}}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answer each request LAT cycles later, in order.
  always @(posedge clk) begin
    #1;
    if (pend.size() > 0 && int'(pend[0].due) == cyc) begin
      c0_rsp_valid = 1'b1;
      c0_rsp_data  = line_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      c0_rsp_valid = 1'b0;
    end
  end

  // Monitor: pop expectations whenever the DUT presents a request or a line.
  always @(negedge clk) begin
    if (c0_req_valid) begin
      req_seen++;
      req_at[cyc] = 1'b1;
      pend.push_back('{due: 32'(cyc + LAT), addr: c0_req_addr});
      if (exp_req.size() == 0) begin
        flag($sformatf("req_unexpected addr=%0h mdata=%0d", c0_req_addr, c0_req_mdata));
      end else begin
        req_t e;
        e = exp_req.pop_front();
        check("req_addr", LW'(c0_req_addr), LW'(e.addr));
        check("req_mdata", LW'(c0_req_mdata), LW'(e.mdata));
      end
    end
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        flag("out_unexpected line");
      end else begin
        out_t o;
        o = exp_out.pop_front();
        check("out_data", out_data, o.data);
        check("out_last", LW'(out_last), LW'(o.last));
      end
    end
    if (busy) busy_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_one_cycle", LW'(prev_done), LW'(1'b0));
    end
    prev_done = done;
  end

  task automatic queue_job(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_req.push_back('{addr: a, mdata: 16'(i)});
      exp_out.push_back('{data: line_of(a), last: (i == n - 1)});
    end
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int n, output int st);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    num_lines = 16'(n);
    st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, input string nm);
    int i;
    i = 0;
    while (done_cnt == d0 && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    if (done_cnt == d0) flag($sformatf("%s_timeout no done after %0d cycles", nm, limit));
  endtask

  task automatic finish_checks(input int d0, input string nm);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done_count"}, LW'(done_cnt - d0), LW'(1));
    check({nm, "_req_left"}, LW'(exp_req.size()), LW'(0));
    check({nm, "_out_left"}, LW'(exp_out.size()), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, d0, r0, k, n;

    // Reset state
    #2;
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_done", LW'(done), LW'(0));
    check("rst_req_valid", LW'(c0_req_valid), LW'(0));
    check("rst_out_valid", LW'(out_valid), LW'(0));
    check("rst_out_last", LW'(out_last), LW'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;

    // Basic four-line job
    d0 = done_cnt;
    queue_job(42'h100, 4);
    start_job(42'h100, 4, st);
    wait_done(d0, 100, "basic");
    finish_checks(d0, "basic");
    check("basic_no_req_at_start", LW'(req_at.exists(st)), LW'(0));

    // Empty job
    d0 = done_cnt;
    busy_seen = 1'b0;
    start_job(42'h0, 0, st);
    wait_done(d0, 10, "zero");
    check("zero_done_cycle", LW'(done_cyc), LW'(st + 2));
    finish_checks(d0, "zero");
    check("zero_busy_never", LW'(busy_seen), LW'(0));

    // Backpressure: credits cap outstanding requests at 16
    out_ready = 1'b0;
    d0 = done_cnt;
    r0 = req_seen;
    queue_job(42'h2000, 40);
    start_job(42'h2000, 40, st);
    repeat (40) @(posedge clk);
    #1;
    check("bp_req_count", LW'(req_seen - r0), LW'(16));
    check("bp_out_valid", LW'(out_valid), LW'(1));
    check("bp_busy", LW'(busy), LW'(1));
    out_ready = 1'b1;
    wait_done(d0, 400, "bp");
    finish_checks(d0, "bp");

    // Almost-full throttling mid-job
    d0 = done_cnt;
    r0 = req_seen;
    queue_job(42'h3000, 30);
    start_job(42'h3000, 30, st);
    for (int i = 0; i < 50 && (req_seen - r0) < 5; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    c0_tx_almfull = 1'b1;
    k = cyc;
    repeat (10) @(posedge clk);
    #1 c0_tx_almfull = 1'b0;
    wait_done(d0, 200, "almfull");
    finish_checks(d0, "almfull");
    n = 0;
    for (int c = k + 2; c <= k + 11; c++) if (req_at.exists(c)) n++;
    check("almfull_blocked", LW'(n), LW'(0));
    check("almfull_resume", LW'(req_at.exists(k + 12)), LW'(1));

    // Address wrap, plus a start pulse mid-job that must be ignored
    d0 = done_cnt;
    queue_job(42'h3FF_FFFF_FFFE, 4);
    start_job(42'h3FF_FFFF_FFFE, 4, st);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 42'h555; num_lines = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 100, "wrap");
    finish_checks(d0, "wrap");

    // Reset mid-job after three of eight requests
    r0 = req_seen;
    queue_job(42'h800, 8);
    start_job(42'h800, 8, st);
    for (int i = 0; i < 50 && (req_seen - r0) < 3; i++) begin
      @(negedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    exp_req.delete();
    exp_out.delete();
    check("mrst_req_count", LW'(req_seen - r0), LW'(3));
    check("mrst_busy", LW'(busy), LW'(0));
    check("mrst_req_valid", LW'(c0_req_valid), LW'(0));
    check("mrst_out_valid", LW'(out_valid), LW'(0));
    check("mrst_out_last", LW'(out_last), LW'(0));
    check("mrst_done", LW'(done), LW'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mrst_stale_dropped", LW'(out_valid), LW'(0));
    check("mrst_no_new_req", LW'(req_seen - r0), LW'(3));
    check("mrst_pend_drained", LW'(pend.size()), LW'(0));
    d0 = done_cnt;
    queue_job(42'h40, 2);
    start_job(42'h40, 2, st);
    wait_done(d0, 100, "post_rst");
    finish_checks(d0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
